// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Shared definitions for the pedal-chain audio path.
//   SAMPLE_WIDTH_DEFAULT : default captured bits per channel
//   rx_state_e           : I2S receiver framing states
//   sample_t             : signed 16-bit audio sample used by the downstream
//                          compression stage and later stages
// -----------------------------------------------------------------------------
package audio_pkg;

  localparam int SAMPLE_WIDTH_DEFAULT = 16;

  typedef enum logic [1:0] {
    ALIGN = 2'd0,
    DELAY = 2'd1,
    SHIFT = 2'd2,
    PAD   = 2'd3
  } rx_state_e;

  typedef logic signed [15:0] sample_t;

endpackage

// File: rtl/i2s_edge_sync.sv
// -----------------------------------------------------------------------------
// i2s_edge_sync
// Brings one asynchronous I2S pin into the clk domain through a STAGES-deep
// flip-flop chain and reports its edges as single-clk pulses.
// Ports:
//   clk  : system clock
//   rst  : asynchronous active-high reset
//   d    : asynchronous input pin
//   rise : one-clk pulse on a synchronised 0->1 transition
//   fall : one-clk pulse on a synchronised 1->0 transition
// STAGES must be at least 2.
// -----------------------------------------------------------------------------
module i2s_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;
  logic              prev_q;
  logic              prev_d;

  // Next state of the synchroniser chain and the previous-sample flop.
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
    prev_d = sync_q[STAGES-1];
  end

  // Synchroniser and previous-sample registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  // Edges compare the two most recent synchronised samples.
  assign rise = sync_q[STAGES-1] & ~prev_q;
  assign fall = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/i2s_audio_rx.sv
// -----------------------------------------------------------------------------
// i2s_audio_rx
// I2S slave receiver: oversamples bclk/lrclk/sdata on the system clock,
// deserialises each channel slot (MSB first, one-bit I2S delay) into a
// SAMPLE_WIDTH sample and presents left/right pairs on valid/ready.
// Ports:
//   clk, rst                   : system clock (>= 4x bclk), async active-high reset
//   i2s_bclk/lrclk/sdata       : I2S pins from the ADC (lrclk 0 = left)
//   sample_left, sample_right  : captured pair
//   sample_valid, sample_ready : pair handshake
//   overrun, overrun_clr       : sticky dropped-pair flag and its clear
// Build option I2S_RX_MONO_MIX_EN: sample_left carries (L + R) >>> 1 instead
// of the raw left sample; sample_right is always the raw right sample.
// -----------------------------------------------------------------------------
module i2s_audio_rx
  import audio_pkg::*;
#(
  parameter int SAMPLE_WIDTH = SAMPLE_WIDTH_DEFAULT,
  parameter int SLOT_WIDTH   = 32,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i2s_bclk,
  input  logic                    i2s_lrclk,
  input  logic                    i2s_sdata,
  output logic [SAMPLE_WIDTH-1:0] sample_left,
  output logic [SAMPLE_WIDTH-1:0] sample_right,
  output logic                    sample_valid,
  input  logic                    sample_ready,
  output logic                    overrun,
  input  logic                    overrun_clr
);

  localparam int BCW = $clog2(SAMPLE_WIDTH + 1);
  localparam int SCW = $clog2(SLOT_WIDTH + 1);

  logic bclk_rise_s;
  logic bclk_fall_s;
  logic lrclk_rise_s;
  logic lrclk_fall_s;
  logic lrclk_edge_s;
  logic sdata_s;

  logic [SYNC_STAGES-1:0] sdata_sync_q;
  logic [SYNC_STAGES-1:0] sdata_sync_d;

  rx_state_e              state_q;
  rx_state_e              state_d;
  logic [BCW-1:0]         bit_cnt_q;
  logic [BCW-1:0]         bit_cnt_d;
  logic [SCW-1:0]         slot_cnt_q;
  logic [SCW-1:0]         slot_cnt_d;
  logic                   chan_q;
  logic                   chan_d;
  logic [SAMPLE_WIDTH-1:0] shift_q;
  logic [SAMPLE_WIDTH-1:0] shift_d;
  logic [SAMPLE_WIDTH-1:0] left_hold_q;
  logic [SAMPLE_WIDTH-1:0] left_hold_d;
  logic                   complete_s;

  logic [SAMPLE_WIDTH-1:0] left_next_s;
  logic [SAMPLE_WIDTH-1:0] sample_left_q;
  logic [SAMPLE_WIDTH-1:0] sample_left_d;
  logic [SAMPLE_WIDTH-1:0] sample_right_q;
  logic [SAMPLE_WIDTH-1:0] sample_right_d;
  logic                   sample_valid_q;
  logic                   sample_valid_d;
  logic                   overrun_q;
  logic                   overrun_d;
  logic                   overrun_set_s;

  i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_bclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (i2s_bclk),
    .rise (bclk_rise_s),
    .fall (bclk_fall_s)
  );

  i2s_edge_sync #(.STAGES(SYNC_STAGES)) u_lrclk_sync (
    .clk  (clk),
    .rst  (rst),
    .d    (i2s_lrclk),
    .rise (lrclk_rise_s),
    .fall (lrclk_fall_s)
  );

  assign lrclk_edge_s = lrclk_rise_s | lrclk_fall_s;

  // sdata goes through the same depth as bclk so a detected bclk rise lines
  // up with the data bit that was present at that rising edge.
  always_comb begin
    sdata_sync_d = {sdata_sync_q[SYNC_STAGES-2:0], i2s_sdata};
  end

  assign sdata_s = sdata_sync_q[SYNC_STAGES-1];

  // Framing FSM: next state, counters and shift/holding registers.
  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    slot_cnt_d  = slot_cnt_q;
    chan_d      = chan_q;
    shift_d     = shift_q;
    left_hold_d = left_hold_q;
    complete_s  = 1'b0;

    // Slot counter tracks elapsed bclk periods and saturates, so an
    // over-long slot simply idles in PAD.
    if (lrclk_edge_s) begin
      slot_cnt_d = '0;
    end else if (bclk_fall_s && (slot_cnt_q != SCW'(SLOT_WIDTH))) begin
      slot_cnt_d = slot_cnt_q + SCW'(1);
    end else begin
      slot_cnt_d = slot_cnt_q;
    end

    case (state_q)
      ALIGN: begin
        if (lrclk_fall_s) begin
          state_d   = DELAY;
          chan_d    = 1'b0;
          bit_cnt_d = '0;
        end else begin
          state_d = ALIGN;
        end
      end
      DELAY: begin
        // An lrclk edge before the sample is complete is a short slot.
        if (lrclk_edge_s) begin
          state_d = ALIGN;
        end else if (bclk_rise_s) begin
          state_d   = SHIFT;
          bit_cnt_d = '0;
        end else begin
          state_d = DELAY;
        end
      end
      SHIFT: begin
        if (lrclk_edge_s) begin
          state_d = ALIGN;
        end else if (bclk_rise_s) begin
          shift_d = {shift_q[SAMPLE_WIDTH-2:0], sdata_s};
          if (bit_cnt_q == BCW'(SAMPLE_WIDTH - 1)) begin
            state_d   = PAD;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BCW'(1);
          end
        end else begin
          state_d = SHIFT;
        end
      end
      PAD: begin
        if (lrclk_rise_s) begin
          if (!chan_q) begin
            left_hold_d = shift_q;
            chan_d      = 1'b1;
            state_d     = DELAY;
          end else begin
            // Rising edge closing a right slot means framing was lost.
            state_d = ALIGN;
          end
        end else if (lrclk_fall_s) begin
          // A fall always opens a left slot; it completes a pair only
          // when it closes a right slot.
          complete_s = chan_q;
          chan_d     = 1'b0;
          state_d    = DELAY;
        end else begin
          state_d = PAD;
        end
      end
      default: begin
        state_d = ALIGN;
      end
    endcase
  end

`ifdef I2S_RX_MONO_MIX_EN
  logic signed [SAMPLE_WIDTH:0] mix_sum_s;

  // Mono mix: sign-extended sum, arithmetic halving (rounds toward -inf).
  always_comb begin
    mix_sum_s   = $signed({left_hold_q[SAMPLE_WIDTH-1], left_hold_q})
                + $signed({shift_q[SAMPLE_WIDTH-1], shift_q});
    left_next_s = SAMPLE_WIDTH'(mix_sum_s >>> 1);
  end
`else
  assign left_next_s = left_hold_q;
`endif

  // At completion shift_q still holds the right sample (FSM is in PAD).
  assign overrun_set_s = complete_s & sample_valid_q & ~sample_ready;

  // Output pair register and handshake.
  always_comb begin
    sample_left_d  = sample_left_q;
    sample_right_d = sample_right_q;
    sample_valid_d = sample_valid_q;
    if (complete_s && (!sample_valid_q || sample_ready)) begin
      sample_left_d  = left_next_s;
      sample_right_d = shift_q;
      sample_valid_d = 1'b1;
    end else if (sample_valid_q && sample_ready) begin
      sample_valid_d = 1'b0;
    end else begin
      sample_valid_d = sample_valid_q;
    end

    if (overrun_set_s) begin
      overrun_d = 1'b1;
    end else if (overrun_clr) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sdata_sync_q   <= '0;
      state_q        <= ALIGN;
      bit_cnt_q      <= '0;
      slot_cnt_q     <= '0;
      chan_q         <= 1'b0;
      shift_q        <= '0;
      left_hold_q    <= '0;
      sample_left_q  <= '0;
      sample_right_q <= '0;
      sample_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
    end else begin
      sdata_sync_q   <= sdata_sync_d;
      state_q        <= state_d;
      bit_cnt_q      <= bit_cnt_d;
      slot_cnt_q     <= slot_cnt_d;
      chan_q         <= chan_d;
      shift_q        <= shift_d;
      left_hold_q    <= left_hold_d;
      sample_left_q  <= sample_left_d;
      sample_right_q <= sample_right_d;
      sample_valid_q <= sample_valid_d;
      overrun_q      <= overrun_d;
    end
  end

  assign sample_left  = sample_left_q;
  assign sample_right = sample_right_q;
  assign sample_valid = sample_valid_q;
  assign overrun      = overrun_q;

endmodule

// File: tb/tb_i2s_audio_rx.sv
// -----------------------------------------------------------------------------
// tb_i2s_audio_rx
// Directed bench for i2s_audio_rx: clk period 10, bclk period 80 (8x),
// 32-bit slots, 16-bit samples. Define I2S_RX_MONO_MIX_EN to check the
// mono-mix build.
// -----------------------------------------------------------------------------
module tb_i2s_audio_rx;

  logic        clk = 1'b0;
  logic        rst;
  logic        i2s_bclk;
  logic        i2s_lrclk;
  logic        i2s_sdata;
  logic [15:0] sample_left;
  logic [15:0] sample_right;
  logic        sample_valid;
  logic        sample_ready;
  logic        overrun;
  logic        overrun_clr;

  int checks = 0;
  int passed = 0;

  // Acceptance monitor: counts handshakes and keeps the last accepted pair.
  int          acc_cnt = 0;
  logic [15:0] acc_l = 16'h0000;
  logic [15:0] acc_r = 16'h0000;
  int          base;

`ifdef I2S_RX_MONO_MIX_EN
  localparam logic [15:0] EXP_NOM_L   = 16'hFFFF;  // 0x7FFF + 0x8000 = -1
  localparam logic [15:0] EXP_BP_L    = 16'h3456;  // 0x68AC >> 1
  localparam logic [15:0] EXP_AWC_L   = 16'hFFFF;  // 0x0F0F + 0xF0F0 = -1
  localparam logic [15:0] EXP_SHORT_L = 16'hFFFF;  // 0x00FF + 0xFF00 = -1
  localparam logic [15:0] EXP_RST_L   = 16'hE009;  // (-16657 + 291) >>> 1
`else
  localparam logic [15:0] EXP_NOM_L   = 16'h7FFF;
  localparam logic [15:0] EXP_BP_L    = 16'h1234;
  localparam logic [15:0] EXP_AWC_L   = 16'h0F0F;
  localparam logic [15:0] EXP_SHORT_L = 16'h00FF;
  localparam logic [15:0] EXP_RST_L   = 16'hBEEF;
`endif

  i2s_audio_rx dut (
    .clk          (clk),
    .rst          (rst),
    .i2s_bclk     (i2s_bclk),
    .i2s_lrclk    (i2s_lrclk),
    .i2s_sdata    (i2s_sdata),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .overrun      (overrun),
    .overrun_clr  (overrun_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (sample_valid === 1'b1 && sample_ready === 1'b1) begin
      acc_cnt = acc_cnt + 1;
      acc_l   = sample_left;
      acc_r   = sample_right;
    end
  end

  // One slot of nper bclk periods; data MSB on the second rising edge.
  task automatic send_slot(input logic lr, input logic [15:0] data, input int nper);
    @(negedge clk);
    for (int k = 0; k < nper; k++) begin
      i2s_bclk  = 1'b0;
      i2s_lrclk = lr;
      i2s_sdata = (k >= 1 && k <= 16) ? data[16-k] : 1'b0;
      #40;
      i2s_bclk = 1'b1;
      #40;
    end
  endtask

  task automatic send_frame(input logic [15:0] l, input logic [15:0] r);
    send_slot(1'b0, l, 32);
    send_slot(1'b1, r, 32);
  endtask

  // Falling lrclk that completes the preceding frame, then a short slot.
  task automatic end_frames();
    send_slot(1'b0, 16'h0000, 4);
  endtask

  task automatic preamble();
    send_slot(1'b1, 16'h0000, 32);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk); #1;
    sample_ready = v;
  endtask

  task automatic test_reset();
    rst = 1'b1; i2s_bclk = 1'b0; i2s_lrclk = 1'b0; i2s_sdata = 1'b0;
    sample_ready = 1'b0; overrun_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (sample_left !== 16'h0000) $display("FAIL reset_left: got %h want 0000", sample_left); else passed++;
    checks++; if (sample_right !== 16'h0000) $display("FAIL reset_right: got %h want 0000", sample_right); else passed++;
    checks++; if (sample_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", sample_valid); else passed++;
    checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b want 0", overrun); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_nominal();
    set_ready(1'b1);
    base = acc_cnt;
    preamble();
    send_frame(16'h7FFF, 16'h8000);
    end_frames();
    @(negedge clk);
    checks++; if (acc_cnt - base !== 1) $display("FAIL nominal_count: got %0d want 1", acc_cnt - base); else passed++;
    checks++; if (acc_l !== EXP_NOM_L) $display("FAIL nominal_left: got %h want %h", acc_l, EXP_NOM_L); else passed++;
    checks++; if (acc_r !== 16'h8000) $display("FAIL nominal_right: got %h want 8000", acc_r); else passed++;
    checks++; if (sample_valid !== 1'b0) $display("FAIL nominal_valid_drop: got %b want 0", sample_valid); else passed++;
  endtask

  task automatic test_backpressure();
    set_ready(1'b0);
    preamble();
    send_frame(16'h1234, 16'h5678);
    send_frame(16'h1111, 16'h2222);
    end_frames();
    @(negedge clk);
    checks++; if (sample_valid !== 1'b1) $display("FAIL bp_valid: got %b want 1", sample_valid); else passed++;
    checks++; if (sample_left !== EXP_BP_L) $display("FAIL bp_left: got %h want %h", sample_left, EXP_BP_L); else passed++;
    checks++; if (sample_right !== 16'h5678) $display("FAIL bp_right: got %h want 5678", sample_right); else passed++;
    checks++; if (overrun !== 1'b1) $display("FAIL bp_overrun_set: got %b want 1", overrun); else passed++;
    @(posedge clk); #1;
    overrun_clr = 1'b1;
    @(posedge clk); #1;
    overrun_clr = 1'b0;
    @(negedge clk);
    checks++; if (overrun !== 1'b0) $display("FAIL bp_overrun_clr: got %b want 0", overrun); else passed++;
    checks++; if (sample_left !== EXP_BP_L) $display("FAIL bp_left_hold: got %h want %h", sample_left, EXP_BP_L); else passed++;
    set_ready(1'b1);
    @(posedge clk);
    @(negedge clk);
    checks++; if (sample_valid !== 1'b0) $display("FAIL bp_valid_drop: got %b want 0", sample_valid); else passed++;
  endtask

  task automatic test_accept_with_completion();
    set_ready(1'b0);
    preamble();
    send_frame(16'hAAAA, 16'h5555);
    send_frame(16'h0F0F, 16'hF0F0);
    @(posedge clk); #1;
    fork
      end_frames();
      begin
        // lrclk falls at this negedge; the pair completes two clk later.
        @(negedge clk);
        @(posedge clk);
        @(posedge clk); #1;
        sample_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++; if (sample_valid !== 1'b1) $display("FAIL awc_valid: got %b want 1", sample_valid); else passed++;
        checks++; if (sample_left !== EXP_AWC_L) $display("FAIL awc_left: got %h want %h", sample_left, EXP_AWC_L); else passed++;
        checks++; if (sample_right !== 16'hF0F0) $display("FAIL awc_right: got %h want F0F0", sample_right); else passed++;
        checks++; if (overrun !== 1'b0) $display("FAIL awc_overrun: got %b want 0", overrun); else passed++;
        @(negedge clk);
        checks++; if (sample_valid !== 1'b0) $display("FAIL awc_valid_drop: got %b want 0", sample_valid); else passed++;
      end
    join
  endtask

  task automatic test_short_slot();
    set_ready(1'b1);
    base = acc_cnt;
    preamble();
    send_slot(1'b0, 16'hABCD, 11);   // delay bit + 10 data bits, then lrclk rises
    send_slot(1'b1, 16'h9999, 32);
    send_frame(16'h00FF, 16'hFF00);
    end_frames();
    @(negedge clk);
    checks++; if (acc_cnt - base !== 1) $display("FAIL short_count: got %0d want 1", acc_cnt - base); else passed++;
    checks++; if (acc_l !== EXP_SHORT_L) $display("FAIL short_left: got %h want %h", acc_l, EXP_SHORT_L); else passed++;
    checks++; if (acc_r !== 16'hFF00) $display("FAIL short_right: got %h want FF00", acc_r); else passed++;
  endtask

  task automatic test_reset_mid_shift();
    set_ready(1'b0);
    preamble();
    send_frame(16'h1357, 16'h2468);
    send_slot(1'b0, 16'h0000, 32);
    send_slot(1'b1, 16'hACE1, 10);
    @(negedge clk);
    checks++; if (sample_valid !== 1'b1) $display("FAIL rst_pre_valid: got %b want 1", sample_valid); else passed++;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checks++; if (sample_valid !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", sample_valid); else passed++;
    checks++; if (sample_left !== 16'h0000) $display("FAIL rst_async_left: got %h want 0000", sample_left); else passed++;
    checks++; if (sample_right !== 16'h0000) $display("FAIL rst_async_right: got %h want 0000", sample_right); else passed++;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    sample_ready = 1'b1;
    base = acc_cnt;
    send_slot(1'b1, 16'hACE1, 22);
    send_frame(16'hBEEF, 16'h0123);
    end_frames();
    @(negedge clk);
    checks++; if (acc_cnt - base !== 1) $display("FAIL rst_count: got %0d want 1", acc_cnt - base); else passed++;
    checks++; if (acc_l !== EXP_RST_L) $display("FAIL rst_left: got %h want %h", acc_l, EXP_RST_L); else passed++;
    checks++; if (acc_r !== 16'h0123) $display("FAIL rst_right: got %h want 0123", acc_r); else passed++;
  endtask

`ifdef I2S_RX_MONO_MIX_EN
  task automatic test_mono_mix();
    set_ready(1'b1);
    preamble();
    send_frame(16'h4000, 16'h2000);
    end_frames();
    @(negedge clk);
    checks++; if (acc_l !== 16'h3000) $display("FAIL mono_mix_pos: got %h want 3000", acc_l); else passed++;
    checks++; if (acc_r !== 16'h2000) $display("FAIL mono_right_raw: got %h want 2000", acc_r); else passed++;
    preamble();
    send_frame(16'hFFFF, 16'h0000);
    end_frames();
    @(negedge clk);
    checks++; if (acc_l !== 16'hFFFF) $display("FAIL mono_mix_neg: got %h want FFFF", acc_l); else passed++;
    checks++; if (acc_r !== 16'h0000) $display("FAIL mono_right_zero: got %h want 0000", acc_r); else passed++;
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_backpressure();
    test_accept_with_completion();
    test_short_slot();
    test_reset_mid_shift();
`ifdef I2S_RX_MONO_MIX_EN
    test_mono_mix();
`endif
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/i2s_audio_rx.md
Name: i2s_audio_rx

Overview:
- Upstream input stage of the pedal chain; receives stereo I2S audio from the external ADC as clock/word-select slave.
- Deserialises each channel slot into a signed 16-bit sample and presents left/right pairs on a valid/ready interface.
- The selected channel feeds the compression stage's 16-bit audio_in.
- All logic runs on the system clock; I2S pins are oversampled and synchronised internally.

Parameters:
- SAMPLE_WIDTH, 16: captured bits per channel, two's complement, MSB first.
- SLOT_WIDTH, 32: bclk periods per channel slot; must be ≥ SAMPLE_WIDTH+1.
- SYNC_STAGES, 2: flip-flop synchroniser depth on i2s_bclk, i2s_lrclk and i2s_sdata.

Ports:
- clk  input  1  system clock; must be ≥ 4× i2s_bclk.
- rst  input  1  asynchronous, active-high reset.
- i2s_bclk  input  1  serial bit clock from ADC.
- i2s_lrclk  input  1  word select: 0 = left, 1 = right.
- i2s_sdata  input  1  serial data; sampled on bclk rising edge.
- sample_left  output  SAMPLE_WIDTH  captured left sample.
- sample_right  output  SAMPLE_WIDTH  captured right sample.
- sample_valid  output  1  left/right pair available.
- sample_ready  input  1  consumer accepts pair when high with sample_valid.
- overrun  output  1  sticky flag: a completed pair was dropped.
- overrun_clr  input  1  single-cycle clear of overrun.

Behaviour:
- Reset: all outputs 0; FSM in ALIGN; bit and slot counters 0; synchroniser flops 0. Reset asserted mid-frame discards the partial frame. After release, the block realigns at the next lrclk falling edge.
- Edge detect: bclk_rise and lrclk edges come from the last two synchronised samples. Each is a one-clk pulse.
- FSM states:
  - ALIGN: wait for lrclk falling edge (start of left slot) → DELAY.
  - DELAY: consume one bclk_rise (I2S one-bit delay) → SHIFT.
  - SHIFT: on each bclk_rise, shift sdata into the channel shift register MSB first. After SAMPLE_WIDTH bits → PAD.
  - PAD: ignore remaining slot bits.
    - lrclk rising edge: latch left shift register into the left holding reg → DELAY (right slot).
    - lrclk falling edge: latch right → completion → DELAY (left slot).
- Short slot: an lrclk edge seen in DELAY or SHIFT before SAMPLE_WIDTH bits are captured → ALIGN; partial data discarded, no completion.
- Long slot: bits beyond SLOT_WIDTH in PAD are ignored; no error is raised.
- Completion: the pair transfers to sample_left/right on the clk after the right-slot-ending lrclk falling edge.
  - sample_valid rises that cycle; latency from the last right-slot data bit ≤ SLOT_WIDTH−SAMPLE_WIDTH bclk periods + 2 clk.
- Handshake:
  - sample_valid stays high and the data stays stable until sample_valid && sample_ready; the following cycle sample_valid = 0.
  - A completion in the same cycle as acceptance loads the new pair and keeps sample_valid = 1 (no bubble).
  - A completion while sample_valid && !sample_ready drops the new pair, keeps the old one, and sets overrun.
- overrun: cleared by overrun_clr. If set and clear occur in the same cycle, set wins.
- Arithmetic: none beyond shifting. Samples pass through bit-exact; no sign extension or scaling.

Optional Feature:
- Macro: I2S_RX_MONO_MIX_EN.
- Defined:
  - sample_left carries the mono mix ((L + R) >>> 1), computed with a 17-bit sign-extended sum.
  - Arithmetic right shift, truncating toward −∞, so −1 + 0 → −1.
  - sample_right carries the raw right sample unchanged.
  - The mix is registered at completion, so latency is unchanged.
- Undefined: sample_left is the raw left sample; no adder is synthesised.

Decomposition:
- Shared package audio_pkg: SAMPLE_WIDTH default; the FSM state enum (ALIGN, DELAY, SHIFT, PAD); the sample typedef, signed 16-bit, reused by the compression and downstream stages.
- One natural sub-module: i2s_edge_sync. It holds the SYNC_STAGES synchroniser plus the rise/fall pulse detector and is instantiated for bclk and lrclk; sdata uses a plain synchroniser of equal depth for alignment.

Test Plan:
- Nominal frame, clk = 8× bclk, SLOT_WIDTH 32:
  - Stimulus: left 0x7FFF, right 0x8000, sample_ready held 1.
  - Required: one sample_valid pulse with sample_left = 0x7FFF, sample_right = 0x8000.
- Back-pressure and overrun:
  - Stimulus: sample_ready = 0 across two frames (0x1234/0x5678, then 0x1111/0x2222).
  - Required: outputs hold 0x1234/0x5678; overrun = 1 after the second frame. Pulse overrun_clr → overrun = 0.
  - Then raise sample_ready: valid drops next clk.
- Accept-with-completion: sample_ready rises the exact cycle a new pair completes → sample_valid stays 1, new data shown, overrun = 0.
- Short slot: lrclk toggles after 10 bits of the left slot → no sample_valid for that frame; the next full frame 0x00FF/0xFF00 is captured correctly.
- Reset mid-SHIFT: assert rst for 3 clk during the right slot → all outputs 0 immediately; the first full frame after the next lrclk falling edge is captured correctly.
- I2S_RX_MONO_MIX_EN defined:
  - left 0x4000, right 0x2000 → sample_left = 0x3000.
  - left 0xFFFF, right 0x0000 → sample_left = 0xFFFF.
